// File: rtl/complex_row_package_feeder_pkg.sv
// Shared definitions for the complex row package feeder: FSM encoding and
// default element/package geometry.
package complex_row_package_feeder_pkg;

  localparam int unsigned ELEMENT_WIDTH_DEF = 64;
  localparam int unsigned NO_OF_UNITS_DEF   = 8;
  localparam int unsigned ADDR_WIDTH_DEF    = 10;
  localparam int unsigned TOTAL_W           = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Slot index width; a single-element package still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/complex_package_assembler.sv
// One shadow register that collects a package of elements, element 0 in the
// top slice; exposes the value it will hold after the current edge.
module complex_package_assembler
  import complex_row_package_feeder_pkg::*;
#(
  parameter int unsigned element_width = ELEMENT_WIDTH_DEF,
  parameter int unsigned no_of_units   = NO_OF_UNITS_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [idx_width(no_of_units)-1:0]      wr_idx,
  input  logic [element_width-1:0]               wr_data,
  output logic [element_width*no_of_units-1:0]   shadow_c
);

  localparam int unsigned IDX_W = idx_width(no_of_units);
  localparam int unsigned ROW_W = element_width * no_of_units;

  logic [ROW_W-1:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < int'(no_of_units); k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        shadow_d[element_width*(no_of_units-k)-1 -: element_width] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  // Lets the issuing edge pick up the last element captured on that same edge.
  assign shadow_c = shadow_d;

endmodule

// File: rtl/complex_row_package_feeder.sv
// Streams packages of no_of_units complex elements from two vector memories
// to the dot-product stage, one package per outsider_read_now pulse.
module complex_row_package_feeder
  import complex_row_package_feeder_pkg::*;
#(
  parameter int unsigned element_width = ELEMENT_WIDTH_DEF,
  parameter int unsigned no_of_units   = NO_OF_UNITS_DEF,
  parameter int unsigned addr_width    = ADDR_WIDTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [TOTAL_W-1:0]                   total,
  input  logic [addr_width-1:0]                base_addr,
  output logic                                 mem_rd_en,
  output logic [addr_width-1:0]                mem_addr,
  input  logic [element_width-1:0]             first_mem_data,
  input  logic [element_width-1:0]             second_mem_data,
  output logic [element_width*no_of_units-1:0] first_row_input,
  output logic [element_width*no_of_units-1:0] second_row_input,
  output logic                                 outsider_read_now,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned IDX_W = idx_width(no_of_units);
  localparam int unsigned ROW_W = element_width * no_of_units;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(no_of_units - 1);

  state_e                state_d, state_q;
  logic                  mem_rd_en_d, mem_rd_en_q;
  logic [addr_width-1:0] mem_addr_d, mem_addr_q;
  logic [IDX_W-1:0]      rd_idx_d, rd_idx_q;
  logic                  cap_en_d, cap_en_q;
  logic [IDX_W-1:0]      cap_idx_d, cap_idx_q;
  logic [TOTAL_W-1:0]    pkg_cnt_d, pkg_cnt_q;
  logic [TOTAL_W-1:0]    pkg_total_d, pkg_total_q;
  logic [ROW_W-1:0]      first_row_d, first_row_q;
  logic [ROW_W-1:0]      second_row_d, second_row_q;
  logic                  pulse_d, pulse_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;

  logic [TOTAL_W-1:0]    job_pkgs_c;
  logic [ROW_W-1:0]      first_shadow_c, second_shadow_c;

  assign job_pkgs_c = total / TOTAL_W'(no_of_units);

  complex_package_assembler #(
    .element_width (element_width),
    .no_of_units   (no_of_units)
  ) u_first_asm (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cap_en_q),
    .wr_idx   (cap_idx_q),
    .wr_data  (first_mem_data),
    .shadow_c (first_shadow_c)
  );

  complex_package_assembler #(
    .element_width (element_width),
    .no_of_units   (no_of_units)
  ) u_second_asm (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cap_en_q),
    .wr_idx   (cap_idx_q),
    .wr_data  (second_mem_data),
    .shadow_c (second_shadow_c)
  );

  // Next-state and registered-output logic; data returns one cycle after each read.
  always_comb begin
    state_d      = state_q;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    rd_idx_d     = rd_idx_q;
    cap_en_d     = mem_rd_en_q;
    cap_idx_d    = rd_idx_q;
    pkg_cnt_d    = pkg_cnt_q;
    pkg_total_d  = pkg_total_q;
    first_row_d  = first_row_q;
    second_row_d = second_row_q;
    pulse_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          pkg_cnt_d   = '0;
          pkg_total_d = job_pkgs_c;
          mem_addr_d  = base_addr;
          rd_idx_d    = '0;
          if (job_pkgs_c == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d     = FETCH;
            mem_rd_en_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (mem_rd_en_q) begin
          mem_addr_d = mem_addr_q + addr_width'(1);
          if (rd_idx_q != LAST_IDX) begin
            mem_rd_en_d = 1'b1;
            rd_idx_d    = rd_idx_q + IDX_W'(1);
          end
        end else begin
          // Last element lands this edge; publish the completed package now.
          state_d      = ISSUE;
          pulse_d      = 1'b1;
          first_row_d  = first_shadow_c;
          second_row_d = second_shadow_c;
          pkg_cnt_d    = pkg_cnt_q + TOTAL_W'(1);
        end
      end
      ISSUE: begin
        if (pkg_cnt_q == pkg_total_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d     = FETCH;
          mem_rd_en_d = 1'b1;
          rd_idx_d    = '0;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      rd_idx_q     <= '0;
      cap_en_q     <= 1'b0;
      cap_idx_q    <= '0;
      pkg_cnt_q    <= '0;
      pkg_total_q  <= '0;
      first_row_q  <= '0;
      second_row_q <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      rd_idx_q     <= rd_idx_d;
      cap_en_q     <= cap_en_d;
      cap_idx_q    <= cap_idx_d;
      pkg_cnt_q    <= pkg_cnt_d;
      pkg_total_q  <= pkg_total_d;
      first_row_q  <= first_row_d;
      second_row_q <= second_row_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd_en         = mem_rd_en_q;
  assign mem_addr          = mem_addr_q;
  assign first_row_input   = first_row_q;
  assign second_row_input  = second_row_q;
  assign outsider_read_now = pulse_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_complex_row_package_feeder.sv
// Randomized self-checking bench: jobs are checked against an address-order
// model of which elements form each package and when pulses/done appear.
module tb_complex_row_package_feeder;

  localparam int unsigned EW    = 64;
  localparam int unsigned N     = 8;
  localparam int unsigned AW    = 10;
  localparam int unsigned ROW_W = EW * N;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       total;
  logic [AW-1:0]     base_addr;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [EW-1:0]     first_mem_data;
  logic [EW-1:0]     second_mem_data;
  logic [ROW_W-1:0]  first_row_input;
  logic [ROW_W-1:0]  second_row_input;
  logic              outsider_read_now;
  logic              busy;
  logic              done;

  logic [EW-1:0] mem1 [DEPTH];
  logic [EW-1:0] mem2 [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  complex_row_package_feeder #(
    .element_width (EW),
    .no_of_units   (N),
    .addr_width    (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .total             (total),
    .base_addr         (base_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_addr          (mem_addr),
    .first_mem_data    (first_mem_data),
    .second_mem_data   (second_mem_data),
    .first_row_input   (first_row_input),
    .second_row_input  (second_row_input),
    .outsider_read_now (outsider_read_now),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      first_mem_data  <= mem1[mem_addr];
      second_mem_data <= mem2[mem_addr];
    end else begin
      first_mem_data  <= {$urandom, $urandom};
      second_mem_data <= {$urandom, $urandom};
    end
  end

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got,
                          input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem1[i] = ramp ? EW'(i) : {$urandom, $urandom};
      mem2[i] = {$urandom, $urandom};
    end
  endtask

  // Package p holds elements base+p*N .. base+p*N+N-1 (mod DEPTH), element 0 on top.
  function automatic logic [ROW_W-1:0] exp_row(input bit second, input int unsigned base,
                                               input int unsigned p);
    logic [ROW_W-1:0] r;
    int unsigned a;
    r = '0;
    for (int k = 0; k < int'(N); k++) begin
      a = (base + p * N + k) % DEPTH;
      r[EW*(N-k)-1 -: EW] = second ? mem2[a] : mem1[a];
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_rd_en"}, ROW_W'(mem_rd_en), '0);
    check_eq({tag, "_addr"},  ROW_W'(mem_addr), '0);
    check_eq({tag, "_pulse"}, ROW_W'(outsider_read_now), '0);
    check_eq({tag, "_busy"},  ROW_W'(busy), '0);
    check_eq({tag, "_done"},  ROW_W'(done), '0);
    check_eq({tag, "_row1"},  first_row_input, '0);
    check_eq({tag, "_row2"},  second_row_input, '0);
  endtask

  // Called at a falling edge; the start is taken on the next rising edge (cycle 0).
  task automatic run_job(input int unsigned tot, input int unsigned base, input bit restart);
    int unsigned pk, exp_done, limit, busy_bad, stable_bad;
    int unsigned rd_addrs[$];
    int unsigned pulse_cyc[$];
    int unsigned done_cyc[$];
    logic [ROW_W-1:0] pf[$];
    logic [ROW_W-1:0] ps[$];
    logic [ROW_W-1:0] prev_f, prev_s;
    pk         = tot / N;
    exp_done   = (pk == 0) ? 1 : pk * (N + 2) + 1;
    limit      = exp_done + 15;
    busy_bad   = 0;
    stable_bad = 0;
    prev_f     = first_row_input;
    prev_s     = second_row_input;
    start      = 1'b1;
    total      = tot;
    base_addr  = AW'(base);
    for (int unsigned c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = restart && (c == 3 || c == exp_done);
      if (start) begin
        total     = 32'($urandom_range(8, 64));
        base_addr = AW'($urandom);
      end
      if (mem_rd_en) rd_addrs.push_back(int'(mem_addr));
      if (outsider_read_now) begin
        pulse_cyc.push_back(c);
        pf.push_back(first_row_input);
        ps.push_back(second_row_input);
      end else if (first_row_input !== prev_f || second_row_input !== prev_s) begin
        stable_bad++;
      end
      prev_f = first_row_input;
      prev_s = second_row_input;
      if (done) done_cyc.push_back(c);
      if (busy !== (c <= exp_done)) busy_bad++;
    end
    start = 1'b0;

    check_eq("n_reads", ROW_W'(rd_addrs.size()), ROW_W'(pk * N));
    foreach (rd_addrs[i])
      check_eq("rd_addr", ROW_W'(rd_addrs[i]), ROW_W'((base + i) % DEPTH));
    check_eq("n_pulses", ROW_W'(pulse_cyc.size()), ROW_W'(pk));
    foreach (pulse_cyc[p]) begin
      check_eq("pulse_cycle", ROW_W'(pulse_cyc[p]), ROW_W'((p + 1) * (N + 2)));
      check_eq("first_row", pf[p], exp_row(1'b0, base, p));
      check_eq("second_row", ps[p], exp_row(1'b1, base, p));
    end
    check_eq("n_done", ROW_W'(done_cyc.size()), ROW_W'(1));
    if (done_cyc.size() > 0)
      check_eq("done_cycle", ROW_W'(done_cyc[0]), ROW_W'(exp_done));
    check_eq("busy_window", ROW_W'(busy_bad), '0);
    check_eq("row_stable", ROW_W'(stable_bad), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned rst_done;
    reset     = 1'b0;
    start     = 1'b0;
    total     = '0;
    base_addr = '0;
    fill_mem(1'b1);
    repeat (2) @(negedge clk);
    check_zero("por");

    // Ramp memory, two packages from address 0; start taken on first edge after release.
    reset = 1'b1;
    run_job(16, 0, 1'b0);

    fill_mem(1'b0);
    run_job(5, $urandom_range(0, DEPTH - 1), 1'b0);
    run_job(8, 1020, 1'b0);
    run_job(8, 100, 1'b1);

    // Abort mid-job with reset, then a clean job from release.
    start     = 1'b1;
    total     = 16;
    base_addr = AW'($urandom);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    rst_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    check_eq("rst_no_done", ROW_W'(rst_done), '0);
    @(negedge clk);
    reset = 1'b1;
    run_job(16, $urandom_range(0, DEPTH - 1), 1'b0);

    run_job(24, $urandom_range(0, DEPTH - 1), 1'b0);

    for (int j = 0; j < 6; j++) begin
      int unsigned t;
      t = $urandom_range(0, 40);
      fill_mem(1'b0);
      run_job(t, $urandom_range(0, DEPTH - 1), (t >= N) && ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_row_package_feeder.md
COMPLEX_ROW_PACKAGE_FEEDER -- requirements
Module: complex_row_package_feeder

Interface
REQ-001 Parameters SHALL be: element_width, default 64, width of one complex element (upper 32 bits real, lower 32 bits imaginary); no_of_units, default 8, number of elements per package; addr_width, default 10, memory address width.
REQ-002 Port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 Port start, input, 1 bit, single-cycle request to stream one dot-product job.
REQ-005 Port total, input, 32 bits, element count of the job; package count is total/no_of_units, truncated.
REQ-006 Port base_addr, input, addr_width bits, start address of both vectors, sampled on the accepted start.
REQ-007 Port mem_rd_en, output, 1 bit, read strobe to both vector memories.
REQ-008 Port mem_addr, output, addr_width bits, read address shared by both memories.
REQ-009 Port first_mem_data, input, element_width bits, first-vector read data, valid exactly one cycle after mem_rd_en.
REQ-010 Port second_mem_data, input, element_width bits, second-vector read data, with the same timing as first_mem_data.
REQ-011 Port first_row_input, output, element_width*no_of_units bits, first-vector package to the dot-product stage.
REQ-012 Port second_row_input, output, element_width*no_of_units bits, second-vector package to the dot-product stage.
REQ-013 Port outsider_read_now, output, 1 bit, one-cycle pulse marking that a new package is valid on both row buses.
REQ-014 Port busy, output, 1 bit, high from the accepted start until done.
REQ-015 Port done, output, 1 bit, one-cycle pulse after the job's last package.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, ISSUE and FINISH.
REQ-017 IDLE SHALL move to FETCH on start; if total/no_of_units equals 0, IDLE SHALL instead move to FINISH.
REQ-018 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-019 In FETCH, mem_rd_en SHALL be high for exactly no_of_units consecutive cycles, with mem_addr incrementing by 1 from the running address, which starts at base_addr.
REQ-020 mem_addr SHALL wrap modulo 2^addr_width.
REQ-021 Returned data SHALL be packed into internal shadow registers MSB-first: element k occupies bits [element_width*(no_of_units-k)-1 -: element_width], so element 0 is in the top slice.
REQ-022 The FSM SHALL leave FETCH for ISSUE one cycle after the last read, when the last data is captured.
REQ-023 In ISSUE, the shadow registers SHALL be copied to first_row_input and second_row_input, outsider_read_now SHALL be high for exactly that one cycle, and the package counter SHALL increment.
REQ-024 The row buses SHALL be written only in ISSUE and SHALL otherwise hold their value, so each package stays stable for at least no_of_units+1 cycles after its pulse.
REQ-025 From ISSUE, the FSM SHALL return to FETCH if packages remain, otherwise go to FINISH.
REQ-026 Consecutive outsider_read_now pulses SHALL therefore be exactly no_of_units+2 cycles apart.
REQ-027 FINISH SHALL assert done for one cycle, clear busy and return to IDLE.
REQ-028 Latency: with start accepted at cycle 0, mem_rd_en SHALL first be high at cycle 1 and the first outsider_read_now SHALL occur at cycle no_of_units+2.
REQ-029 Elements beyond total/no_of_units*no_of_units SHALL never be read.

Reset
REQ-030 When reset is low, the block SHALL asynchronously force: FSM to IDLE; mem_rd_en, outsider_read_now, busy and done to 0; mem_addr, the counters, the shadow registers and both row buses to 0.
REQ-031 Reset asserted mid-job SHALL abort the job with no done pulse.
REQ-032 After reset is released, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the default element_width and no_of_units constants.
REQ-034 The FSM, address counter and package counter SHALL be implemented inline.
REQ-035 One sub-module, complex_package_assembler, SHALL hold a single shadow register with its MSB-first slice write; it is instantiated once per vector.

Verification
REQ-036 Scenario: total=16, base_addr=0, memory word i = i -> two pulses at cycles 10 and 20; package 0 top slice = 0, bottom slice = 7; package 1 top slice = 8; done at cycle 21.
REQ-037 Scenario: total=5 -> done one cycle after start, no mem_rd_en and no outsider_read_now.
REQ-038 Scenario: base_addr=1020, addr_width=10, total=8 -> addresses read are 1020 to 1023 then 0 to 3.
REQ-039 Scenario: start pulsed again during a job with total=8 -> ignored; exactly one pulse and one done.
REQ-040 Scenario: reset driven low at cycle 5 of a total=16 job -> all outputs 0 immediately, no done; a new start after release gives a normal first pulse at cycle 10.
REQ-041 Scenario: total=24 -> row buses change only on pulse cycles and are stable for at least 9 cycles after each pulse.
